// File: rtl/mem_access_unit.sv
// Load/store unit driving a 32-bit BRAM word port for RV32I byte-addressed accesses.
// Sub-word stores are read-modify-write; illegal, misaligned or out-of-range accesses never strobe memory.
module mem_access_unit #(
  parameter int WORDS = 10
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WORDS-1:0] mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             mem_wr_no,
  output logic             mem_rd_no,
  input  logic [31:0]      mem_data_i,
  output logic [2:0]       dbg_state_o
);

  // Handshake: req_i is taken only on a cycle where busy_o is low; each accepted
  // request yields exactly one done_o pulse, with err_o high on that pulse if rejected.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        valid;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign range_ok = (addr_i[31:WORDS+2] == '0);
  assign valid    = f3_ok && align_ok && range_ok;

  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    if (we_i) begin
      f3_ok = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end
    case (funct3_i[1:0])
      2'b01:   align_ok = (addr_i[0] == 1'b0);
      2'b10:   align_ok = (addr_i[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  // Lane selection and merge both work on the word returned during RD.
  always_comb begin
    lane_b    = mem_data_i[7:0];
    lane_h    = addr_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    load_val  = mem_data_i;
    merge_val = mem_data_i;
    case (addr_q)
      2'd0:    lane_b = mem_data_i[7:0];
      2'd1:    lane_b = mem_data_i[15:8];
      2'd2:    lane_b = mem_data_i[23:16];
      default: lane_b = mem_data_i[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'h0, lane_b};
      3'b101:  load_val = {16'h0, lane_h};
      default: load_val = mem_data_i;
    endcase
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q)
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 2'b00;
      wdata_q    <= 16'h0;
      rdata_o    <= 32'h0;
      mem_addr_o <= '0;
      mem_data_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            funct3_q   <= funct3_i;
            addr_q     <= addr_i[1:0];
            wdata_q    <= wdata_i[15:0];
            mem_addr_o <= addr_i[WORDS+1:2];
            if (!valid) begin
              state <= ERR;
            end else if (we_i && (funct3_i[1:0] == 2'b10)) begin
              mem_data_o <= wdata_i;
              state      <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_data_o <= merge_val;
            state      <= WR;
          end else begin
            rdata_o <= load_val;
            state   <= DONE;
          end
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight from the state register so reset releases them without a clock.
  assign mem_rd_no   = (state != RD);
  assign mem_wr_no   = (state != WR);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE) || (state == ERR);
  assign err_o       = (state == ERR);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: negedge BRAM model, an access-level reference model feeding an
// expected queue, and a per-cycle compare process checking strobes, timing and results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr_n;
  logic        mem_rd_n;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_unit #(.WORDS(10)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .req_i       (req),
    .we_i        (we),
    .funct3_i    (funct3),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_wr_no   (mem_wr_n),
    .mem_rd_no   (mem_rd_n),
    .mem_data_i  (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  // BRAM: samples strobes on the falling edge
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h1234_5678;
      mem[5]  <= 32'h1111_000B;
      mem[18] <= 32'hD0B0_A090;
      loaded  <= 1'b1;
    end else begin
      if (!mem_rd_n) mem_rdata <= mem[mem_addr];
      if (!mem_wr_n) mem[mem_addr] <= mem_data;
    end
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [9:0]  word;
    logic [31:0] wdata;
  } exp_t;

  logic [$bits(exp_t)-1:0] exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rdata;
  int          cyc;
  int          rd_cnt;
  int          wr_cnt;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Access-level reference: size/alignment arithmetic and mask-based merging
  function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int acc);
    exp_t        e;
    int          size;
    int          sh;
    logic        legal;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e       = '0;
    e.word  = a[11:2];
    e.rdata = last_rdata;
    if (!legal || (a % size) != 0 || a >= 32'h1000) begin
      e.err = 1'b1;
      e.cyc = acc;
      return e;
    end
    sh   = 8 * int'(a % 4);
    word = ref_mem[a[11:2]];
    mask = (size == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * size)) - 32'h1) << sh);
    if (!w) begin
      v = (word & mask) >> sh;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
      last_rdata = v;
      e.rdata    = v;
      e.rd       = 2'd1;
      e.cyc      = acc + 1;
    end else begin
      word               = (word & ~mask) | ((wd << sh) & mask);
      ref_mem[a[11:2]]   = word;
      e.wdata            = word;
      e.rd               = (size == 4) ? 2'd0 : 2'd1;
      e.wr               = 2'd1;
      e.cyc              = acc + ((size == 4) ? 1 : 2);
    end
    return e;
  endfunction

  task automatic compare_loop();
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!reset_ni) begin
        rd_cnt = 0;
        wr_cnt = 0;
        continue;
      end
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("strobe_overlap", 32'(mem_rd_n | mem_wr_n), 32'd1);
      if (!mem_rd_n || !mem_wr_n) begin
        if (exp_q.size() == 0) begin
          chk("stray_strobe", 32'({mem_rd_n, mem_wr_n}), 32'd3);
        end else begin
          e = exp_q[0];
          chk("mem_addr", 32'(mem_addr), 32'(e.word));
          if (!mem_rd_n) rd_cnt++;
          if (!mem_wr_n) begin
            wr_cnt++;
            chk("mem_data", mem_data, e.wdata);
          end
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("stray_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          chk("rd_strobes", rd_cnt, 32'(e.rd));
          chk("wr_strobes", wr_cnt, 32'(e.wr));
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end else begin
        chk("err_without_done", 32'(err), 32'd0);
      end
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req    = 1'b1;
    we     = w;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
  endtask

  // Called while the unit is idle; returns 3 time units after the accept edge
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(w, f3, a, wd);
    @(posedge clk);
    #1;
    exp_q.push_back(model(w, f3, a, wd, cyc));
    #2;
    req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #3;
    end
    req = 1'b0;
    chk("timeout_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3;
  endtask

  initial begin
    exp_t d;
    n_cmp = 0; n_fail = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0;
    last_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[0]  = 32'h1234_5678;
    ref_mem[5]  = 32'h1111_000B;
    ref_mem[18] = 32'hD0B0_A090;
    reset_ni = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    fork
      compare_loop();
    join_none

    repeat (2) @(posedge clk);
    #3;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_wr_n", 32'(mem_wr_n), 32'd1);
    chk("rst_rd_n", 32'(mem_rd_n), 32'd1);
    reset_ni = 1'b1;
    @(posedge clk);
    #3;

    // Loads from word 18 = D0B0A090
    issue(1'b0, 3'b000, 32'h49, 32'h0); wait_done(); chk("lb_0x49", rdata, 32'hFFFF_FFA0);
    issue(1'b0, 3'b100, 32'h49, 32'h0); wait_done(); chk("lbu_0x49", rdata, 32'h0000_00A0);
    issue(1'b0, 3'b001, 32'h4A, 32'h0); wait_done(); chk("lh_0x4a", rdata, 32'hFFFF_D0B0);
    issue(1'b0, 3'b101, 32'h4A, 32'h0); wait_done(); chk("lhu_0x4a", rdata, 32'h0000_D0B0);
    issue(1'b0, 3'b010, 32'h48, 32'h0); wait_done(); chk("lw_0x48", rdata, 32'hD0B0_A090);
    issue(1'b0, 3'b000, 32'h4B, 32'h0); wait_done(); chk("lb_0x4b", rdata, 32'hFFFF_FFD0);

    // Stores into word 5 = 1111000B
    issue(1'b1, 3'b000, 32'h16, 32'h0000_0055); wait_done();
    chk("sb_mem5", mem[5], 32'h1155_000B);
    chk("sb_rdata_held", rdata, 32'hFFFF_FFD0);
    issue(1'b0, 3'b010, 32'h14, 32'h0); wait_done(); chk("lw_after_sb", rdata, 32'h1155_000B);
    issue(1'b1, 3'b010, 32'h14, 32'hCAFE_BABE); wait_done();
    chk("sw_mem5", mem[5], 32'hCAFE_BABE);
    issue(1'b0, 3'b010, 32'h14, 32'h0); wait_done(); chk("lw_after_sw", rdata, 32'hCAFE_BABE);

    // Rejected accesses
    issue(1'b0, 3'b010, 32'h06, 32'h0);         wait_done();
    issue(1'b0, 3'b001, 32'h03, 32'h0);         wait_done();
    issue(1'b1, 3'b010, 32'h1000, 32'hDEAD_0000); wait_done();
    issue(1'b0, 3'b011, 32'h48, 32'h0);         wait_done();
    issue(1'b1, 3'b100, 32'h14, 32'h0);         wait_done();
    chk("err_mem0", mem[0], 32'h1234_5678);
    chk("err_mem1", mem[1], 32'h0);
    chk("err_mem18", mem[18], 32'hD0B0_A090);
    chk("err_mem5", mem[5], 32'hCAFE_BABE);
    chk("err_rdata_held", rdata, 32'hCAFE_BABE);

    // SH aborted by reset while in RD
    drive(1'b1, 3'b001, 32'h16, 32'h0000_BEEF);
    @(posedge clk);
    #1;
    d      = '0;
    d.word = 10'd5;
    d.cyc  = 32'hFFFF_FFFF;
    exp_q.push_back(d);
    #1;
    chk("abort_rd_low", 32'(mem_rd_n), 32'd0);
    #1;
    req      = 1'b0;
    reset_ni = 1'b0;
    #1;
    chk("abort_rd_released", 32'(mem_rd_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_n", 32'(mem_wr_n), 32'd1);
    exp_q.delete();
    last_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #3;
      chk("abort_wr_n_hold", 32'(mem_wr_n), 32'd1);
    end
    reset_ni = 1'b1;
    @(posedge clk);
    #3;
    chk("abort_mem5", mem[5], 32'hCAFE_BABE);
    chk("abort_rdata_reset", rdata, 32'h0);
    issue(1'b0, 3'b010, 32'h14, 32'h0); wait_done(); chk("lw_after_abort", rdata, 32'hCAFE_BABE);

    // req held high across two LWs: second accepted three edges after the first
    drive(1'b0, 3'b010, 32'h48, 32'h0);
    @(posedge clk);
    #1;
    exp_q.push_back(model(1'b0, 3'b010, 32'h48, 32'h0, cyc));
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(model(1'b0, 3'b010, 32'h48, 32'h0, cyc));
    #2;
    wait_done();
    chk("b2b_rdata", rdata, 32'hD0B0_A090);
    chk("b2b_idle", 32'(busy), 32'd0);

    repeat (2) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
